// File: rtl/pdp_fetch_ctrl.sv
// pdp_fetch_ctrl: PDP-11 instruction-fetch sequencer; owns the PC, reads program
// memory and hands one instruction at a time to the execute core.
module pdp_fetch_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic              i_abort,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-2:0] o_mem_addr,
    input  logic [15:0]       i_mem_rdata,
    input  logic              i_mem_present,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [15:0]       o_instr_word,
    output logic [ADDR_W-1:0] o_instr_pc,
    input  logic              i_ex_done,
    input  logic              i_br_taken,
    input  logic [7:0]        i_br_offset,
    input  logic              i_jmp_taken,
    input  logic [ADDR_W-1:0] i_jmp_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [31:0]       o_fetch_count,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_err
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RSP, S_ISSUE, S_EXEC, S_HALT} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_pc, r_instr_pc, w_seq_pc, w_br_pc, w_exec_pc;
    logic [15:0]       r_instr_word;
    logic [31:0]       r_fetch_count;
    logic              r_err, w_start, w_jmp_odd;

    assign w_start   = (r_state == S_IDLE || r_state == S_HALT) && i_start;
    assign w_jmp_odd = i_jmp_taken && i_jmp_target[0];
    assign w_seq_pc  = r_pc + ADDR_W'(2);
    // branch offset counts words, so sign-extend and scale to bytes
    assign w_br_pc   = w_seq_pc + {{(ADDR_W-9){i_br_offset[7]}}, i_br_offset, 1'b0};
    assign w_exec_pc = i_jmp_taken ? i_jmp_target : i_br_taken ? w_br_pc : w_seq_pc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: w_next = i_start ? S_RD : r_state;
            S_RD:           w_next = S_RSP;
            S_RSP:          w_next = i_mem_present ? S_ISSUE : S_HALT;
            S_ISSUE:        w_next = i_instr_ready ? S_EXEC : S_ISSUE;
            S_EXEC:         w_next = !i_ex_done ? S_EXEC : w_jmp_odd ? S_HALT : S_RD;
            default:        w_next = S_IDLE;
        endcase
        if (i_abort)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_fetch_count <= '0;
            r_instr_word  <= '0;
            r_instr_pc    <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!i_abort) begin
                if (w_start) begin
                    r_pc          <= {i_start_addr[ADDR_W-1:1], 1'b0};
                    r_fetch_count <= '0;
                    r_err         <= 1'b0;
                end
                if (r_state == S_RSP && i_mem_present) begin
                    r_instr_word <= i_mem_rdata;
                    r_instr_pc   <= r_pc;
                end
                if (r_state == S_ISSUE && i_instr_ready)
                    r_fetch_count <= r_fetch_count + 32'd1;
                if (r_state == S_EXEC && i_ex_done) begin
                    if (w_jmp_odd)
                        r_err <= 1'b1;
                    else
                        r_pc <= w_exec_pc;
                end
            end
        end
    end

    assign o_mem_rd_en   = r_state == S_RD;
    assign o_mem_addr    = r_pc[ADDR_W-1:1];
    assign o_instr_valid = r_state == S_ISSUE;
    assign o_instr_word  = r_instr_word;
    assign o_instr_pc    = r_instr_pc;
    assign o_pc          = r_pc;
    assign o_fetch_count = r_fetch_count;
    assign o_busy        = r_state != S_IDLE && r_state != S_HALT;
    assign o_halted      = r_state == S_HALT;
    assign o_err         = r_err;
endmodule

// File: doc/pdp_fetch_ctrl.md
# pdp_fetch_ctrl

Instruction-fetch sequencer for the PDP-11 simulator. It owns the program counter, reads 16-bit words from the loaded program memory, and presents one instruction at a time to the PDP11 execute core over a valid/ready handshake. It then waits for the core's completion and redirect report (branch or jump) and computes the next fetch address. It stops when it reaches an unloaded memory word or a malformed jump target.

## Interface
- ADDR_W, 16, byte-address width; memory holds 2^(ADDR_W-1) words
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin fetching at start_addr; sampled only in IDLE or HALT
- start_addr  in  ADDR_W  initial byte address; bit 0 ignored (forced 0)
- abort  in  1  return to IDLE from any state at the next edge
- mem_rd_en  out  1  memory read strobe, one cycle per fetch
- mem_addr  out  ADDR_W-1  word index = pc[ADDR_W-1:1]
- mem_rdata  in  16  read word, valid the cycle after mem_rd_en
- mem_present  in  1  word loaded flag, valid with mem_rdata
- instr_valid  out  1  instr_word/instr_pc valid to core
- instr_ready  in  1  core accepts instruction
- instr_word  out  16  fetched instruction
- instr_pc  out  ADDR_W  byte address of instr_word
- ex_done  in  1  core finished current instruction (single-cycle pulse)
- br_taken  in  1  with ex_done: take branch
- br_offset  in  8  signed word offset for branch
- jmp_taken  in  1  with ex_done: jump
- jmp_target  in  ADDR_W  absolute byte target
- pc  out  ADDR_W  current fetch address
- fetch_count  out  32  instructions handed to core since start
- busy  out  1  state not IDLE/HALT
- halted  out  1  in HALT
- err  out  1  HALT caused by odd jump target

## Operation
- States: IDLE, RD, RSP, ISSUE, EXEC, HALT.
- IDLE: start=1 -> pc<=start_addr&~1, fetch_count<=0, err<=0, go to RD.
- RD: mem_rd_en=1, mem_addr=pc[ADDR_W-1:1]; go to RSP.
- RSP: mem_present=0 -> HALT (err=0). Otherwise instr_word<=mem_rdata, instr_pc<=pc; go to ISSUE.
- ISSUE: instr_valid=1. instr_word and instr_pc are held stable until instr_ready=1. On a handshake, fetch_count+=1 and go to EXEC.
- EXEC: wait for ex_done. On ex_done:
  - jmp_taken=1 (priority over br_taken): jmp_target[0]=1 -> HALT with err=1; otherwise pc<=jmp_target.
  - br_taken=1: pc<=pc+2+(sext(br_offset)<<1).
  - Neither: pc<=pc+2.
  - Then go to RD.
- HALT: outputs hold. start restarts as from IDLE.
- All PC arithmetic is modulo 2^ADDR_W. 16'hFFFE+2 wraps to 0, and a branch below 0 wraps the same way.
- abort takes priority over every transition: -> IDLE, instr_valid=0, pc and fetch_count hold.
- start outside IDLE/HALT is ignored. ex_done outside EXEC is ignored. br/jmp inputs are don't-care unless ex_done=1.

## Timing
- Reset values (async, immediate): state=IDLE, pc=0, fetch_count=0, instr_word=0, instr_pc=0, mem_rd_en=0, instr_valid=0, busy=0, halted=0, err=0.
- mem_rd_en, instr_valid, busy and halted are Moore outputs decoded from the state register.
- Latency: start edge -> RD at cycle 1, RSP at 2, instr_valid at 3.
- Minimum 4 cycles per instruction: RD, RSP, ISSUE (ready=1), EXEC (ex_done=1).
- Memory has a fixed 1-cycle read latency and no backpressure.
- instr_valid never drops without a handshake, except on abort or reset.
- Reset asserted mid-operation clears everything asynchronously. The first fetch after reset requires a new start.

## Test plan
- Linear run: start_addr=16'o1000; words at 0o1000/0o1002/0o1004 present, 0o1006 absent; ready=1, ex_done one cycle after each handshake -> instr_pc 0o1000, 0o1002, 0o1004; halted=1, err=0, fetch_count=3.
- Branch: word at 0o1000 executes with br_taken=1, br_offset=8'hFD (-3) -> next mem_addr = (0o1002-6)>>1, i.e. byte 0o774. Repeat with offset=8'h7F -> pc=0o1000+2+254.
- Jump vs branch: ex_done with jmp_taken=1, jmp_target=16'h2000, and br_taken=1 -> pc=16'h2000. Repeat with jmp_target=16'h2001 -> HALT, err=1, no further mem_rd_en.
- Backpressure: hold instr_ready=0 for 5 cycles in ISSUE -> instr_valid stays 1, instr_word stable, fetch_count unchanged until ready=1.
- Wrap: start_addr=16'hFFFE with the word present, no redirect -> next mem_addr=0.
- Reset/abort mid-run: assert abort in EXEC -> IDLE next edge, pc held. Drop rst_n in ISSUE -> instr_valid=0 immediately, all outputs at reset values. start after each -> restarts at start_addr with fetch_count=0.
